lsu_mem_port: RTL and testbench

//  Parametrised load/store memory port sitting between EX/LS pipeline register and memory system.

---
 rtl/lsu_mem_port_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/lsu_mem_port.sv | 236 +++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_port_pkg.sv
// Shared constants and types for the LSU memory port.
package lsu_mem_port_pkg;

    // RISC-V load/store funct3 encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // AXI4 constants
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Default cacheable window
    localparam logic [63:0] PMEM_BASE_DEF  = 64'h0000_0000_8000_0000;
    localparam logic [63:0] PMEM_LIMIT_DEF = 64'h0000_0000_8800_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CACHE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B,
        ST_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: store mask/data shift and load extract/extend.
module lsu_lane_align
    import lsu_mem_port_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    localparam int unsigned OFF_W = $clog2(DATA_W / 8),
    localparam int unsigned BYTES = DATA_W / 8
) (
    input  logic [OFF_W-1:0]  off,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] raw,
    output logic [BYTES-1:0]  wmask,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata
);

    int unsigned        lanes;
    int unsigned        nbits;
    int unsigned        sh_amt;
    logic [DATA_W-1:0]  sh;
    logic [DATA_W-1:0]  keep;
    logic               sbit;

    // Shift store lanes up to the offset; shift load lanes down and extend
    always_comb begin
        lanes    = 32'(1) << func3[1:0];
        sh_amt   = 32'(off) * 32'd8;
        wmask    = (BYTES'(1) << lanes) - BYTES'(1);
        wmask    = wmask << 32'(off);
        wdata_sh = wdata << sh_amt;

        nbits = lanes * 32'd8;
        if (nbits > DATA_W) begin
            nbits = DATA_W;
        end
        sh    = raw >> sh_amt;
        // width == DATA_W makes the shift overflow to 0, so keep becomes all ones
        keep  = (DATA_W'(1) << nbits) - DATA_W'(1);
        sbit  = ~func3[2] & (|(sh & (DATA_W'(1) << (nbits - 32'd1))));
        rdata = (sh & keep) | (sbit ? ~keep : '0);
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port routing accesses to the data cache or an AXI4 device bus.
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 64,
    parameter logic [63:0] PMEM_BASE  = PMEM_BASE_DEF,
    parameter logic [63:0] PMEM_LIMIT = PMEM_LIMIT_DEF,
    localparam int unsigned OFF_W     = $clog2(DATA_W / 8),
    localparam int unsigned BYTES     = DATA_W / 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_ren,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_func3,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              resp_skipref,
    output logic              cache_valid,
    output logic              cache_op,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wdata,
    output logic [BYTES-1:0]  cache_wmask,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic              cache_dataok,
    output logic              ar_valid,
    input  logic              ar_ready,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [7:0]        ar_len,
    output logic [2:0]        ar_size,
    output logic [1:0]        ar_burst,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [ADDR_W-1:0] aw_addr,
    output logic [7:0]        aw_len,
    output logic [2:0]        aw_size,
    output logic [1:0]        aw_burst,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] w_data,
    output logic [BYTES-1:0]  w_strb,
    output logic              w_last,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [1:0]        b_resp
);

    lsu_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        func3_q;
    logic              op_q;
    logic              cache_valid_q;
    logic              aw_done;
    logic              w_done;

    logic              accept;
    logic [3:0]        size_bytes;
    logic              bad;
    logic              cacheable;
    logic [BYTES-1:0]  wmask_s;
    logic [DATA_W-1:0] wdata_sh_s;
    logic [DATA_W-1:0] rdata_ext_s;
    logic [DATA_W-1:0] raw_s;
    logic              aw_hs;
    logic              w_hs;
    logic              unused_r_last;

    // Accept decode, legality and routing for the incoming request
    always_comb begin
        accept     = req_valid && req_ready && (req_ren || req_wen);
        size_bytes = 4'(1) << req_func3[1:0];
        bad        = (size_bytes > 4'(BYTES)) ||
                     ((req_addr[OFF_W-1:0] & OFF_W'(size_bytes - 4'd1)) != '0);
        cacheable  = (req_addr >= ADDR_W'(PMEM_BASE)) && (req_addr < ADDR_W'(PMEM_LIMIT));
        raw_s      = (state == ST_R) ? r_data : cache_rdata;
        aw_hs      = aw_valid && aw_ready;
        w_hs       = w_valid && w_ready;
    end

    assign unused_r_last = r_last;

    lsu_lane_align #(.DATA_W(DATA_W)) u_align (
        .off      (addr_q[OFF_W-1:0]),
        .func3    (func3_q),
        .wdata    (wdata_q),
        .raw      (raw_s),
        .wmask    (wmask_s),
        .wdata_sh (wdata_sh_s),
        .rdata    (rdata_ext_s)
    );

    // Bus-side views of the latched request
    assign cache_valid = cache_valid_q && !cache_dataok;
    assign cache_op    = op_q;
    assign cache_addr  = addr_q;
    assign cache_wdata = wdata_sh_s;
    assign cache_wmask = wmask_s;
    assign ar_addr     = addr_q;
    assign ar_len      = 8'd0;
    assign ar_size     = {1'b0, func3_q[1:0]};
    assign ar_burst    = AXI_BURST_INCR;
    assign aw_addr     = addr_q;
    assign aw_len      = 8'd0;
    assign aw_size     = {1'b0, func3_q[1:0]};
    assign aw_burst    = AXI_BURST_INCR;
    assign w_data      = wdata_sh_s;
    assign w_strb      = wmask_s;
    assign w_last      = 1'b1;

    // Access FSM with registered handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            func3_q       <= '0;
            op_q          <= 1'b0;
            req_ready     <= 1'b1;
            cache_valid_q <= 1'b0;
            ar_valid      <= 1'b0;
            r_ready       <= 1'b0;
            aw_valid      <= 1'b0;
            w_valid       <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            b_ready       <= 1'b0;
            resp_valid    <= 1'b0;
            resp_err      <= 1'b0;
            resp_skipref  <= 1'b0;
            resp_rdata    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q       <= req_addr;
                        wdata_q      <= req_wdata;
                        func3_q      <= req_func3;
                        op_q         <= !req_ren;
                        req_ready    <= 1'b0;
                        resp_rdata   <= '0;
                        resp_err     <= 1'b0;
                        resp_skipref <= 1'b0;
                        if (bad) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (cacheable) begin
                            state         <= ST_CACHE;
                            cache_valid_q <= 1'b1;
                        end else begin
                            resp_skipref <= 1'b1;
                            if (req_ren) begin
                                state    <= ST_AR;
                                ar_valid <= 1'b1;
                            end else begin
                                state    <= ST_AWW;
                                aw_valid <= 1'b1;
                                w_valid  <= 1'b1;
                                aw_done  <= 1'b0;
                                w_done   <= 1'b0;
                            end
                        end
                    end
                end
                ST_CACHE: begin
                    if (cache_dataok) begin
                        cache_valid_q <= 1'b0;
                        resp_rdata    <= op_q ? '0 : rdata_ext_s;
                        resp_valid    <= 1'b1;
                        state         <= ST_RESP;
                    end
                end
                ST_AR: begin
                    if (ar_ready) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= ST_R;
                    end
                end
                ST_R: begin
                    if (r_valid) begin
                        r_ready    <= 1'b0;
                        resp_err   <= (r_resp != AXI_RESP_OKAY);
                        resp_rdata <= (r_resp != AXI_RESP_OKAY) ? '0 : rdata_ext_s;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_AWW: begin
                    if (aw_hs) begin
                        aw_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        b_ready <= 1'b1;
                        state   <= ST_B;
                    end
                end
                ST_B: begin
                    if (b_valid) begin
                        b_ready    <= 1'b0;
                        resp_err   <= (b_resp != AXI_RESP_OKAY);
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed self-checking bench for lsu_mem_port (DATA_W=64).
module tb_lsu_mem_port;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_ren, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid, resp_ready, resp_err, resp_skipref;
    logic [63:0] resp_rdata;
    logic        cache_valid, cache_op, cache_dataok;
    logic [63:0] cache_addr, cache_wdata, cache_rdata;
    logic [7:0]  cache_wmask;
    logic        ar_valid, ar_ready;
    logic [63:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready, r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_valid, aw_ready;
    logic [63:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lsu_mem_port dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_skipref(resp_skipref),
        .cache_valid(cache_valid), .cache_op(cache_op), .cache_addr(cache_addr),
        .cache_wdata(cache_wdata), .cache_wmask(cache_wmask), .cache_rdata(cache_rdata),
        .cache_dataok(cache_dataok),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
        .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
        .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request for exactly one accepting edge
    task automatic issue(input logic ren, input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [2:0] f3);
        req_valid = 1'b1; req_ren = ren; req_wen = wen;
        req_addr = addr; req_wdata = wdata; req_func3 = f3;
        tick();
        req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
    endtask

    // Complete the response handshake
    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        checks++; if ({ar_valid, aw_valid, w_valid, cache_valid} !== 4'b0) begin errors++; $display("FAIL rst_valids: got %b expected 0000", {ar_valid, aw_valid, w_valid, cache_valid}); end
        checks++; if ({r_ready, b_ready} !== 2'b0) begin errors++; $display("FAIL rst_readies: got %b expected 00", {r_ready, b_ready}); end
        checks++; if ({resp_err, resp_skipref} !== 2'b0) begin errors++; $display("FAIL rst_err_skip: got %b expected 00", {resp_err, resp_skipref}); end
    endtask

    task automatic test_cache_load();
        issue(1'b1, 1'b0, 64'h8000_0004, 64'h0, 3'b010);
        checks++; if (cache_valid !== 1'b1) begin errors++; $display("FAIL cl_cache_valid: got %b expected 1", cache_valid); end
        checks++; if (cache_op !== 1'b0) begin errors++; $display("FAIL cl_cache_op: got %b expected 0", cache_op); end
        checks++; if (cache_addr !== 64'h8000_0004) begin errors++; $display("FAIL cl_cache_addr: got %h expected 0000000080000004", cache_addr); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL cl_req_ready: got %b expected 0", req_ready); end
        tick();
        checks++; if (cache_valid !== 1'b1) begin errors++; $display("FAIL cl_cache_hold: got %b expected 1", cache_valid); end
        cache_rdata = 64'h8765_4321_FFFF_FFF0;
        cache_dataok = 1'b1;
        #1;
        checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL cl_cache_drop: got %b expected 0", cache_valid); end
        tick();
        cache_dataok = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL cl_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_8765_4321) begin errors++; $display("FAIL cl_rdata: got %h expected ffffffff87654321", resp_rdata); end
        checks++; if ({resp_err, resp_skipref} !== 2'b00) begin errors++; $display("FAIL cl_err_skip: got %b expected 00", {resp_err, resp_skipref}); end
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("FAIL cl_no_ar: got %b expected 0", ar_valid); end
        finish_resp();
        checks++; if ({resp_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL cl_idle: got %b expected 01", {resp_valid, req_ready}); end
    endtask

    task automatic test_cache_store();
        issue(1'b0, 1'b1, 64'h8000_0002, 64'h0000_0000_0000_BEEF, 3'b001);
        checks++; if (cache_op !== 1'b1) begin errors++; $display("FAIL cs_op: got %b expected 1", cache_op); end
        checks++; if (cache_wmask !== 8'h0C) begin errors++; $display("FAIL cs_wmask: got %h expected 0c", cache_wmask); end
        checks++; if (cache_wdata !== 64'h0000_0000_BEEF_0000) begin errors++; $display("FAIL cs_wdata: got %h expected 00000000beef0000", cache_wdata); end
        cache_rdata = 64'h1111_2222_3333_4444;
        cache_dataok = 1'b1;
        tick();
        cache_dataok = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL cs_resp_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL cs_rdata: got %h expected 0", resp_rdata); end
        finish_resp();
    endtask

    task automatic test_device_store_byte();
        issue(1'b0, 1'b1, 64'hA000_03F9, 64'h0000_0000_0000_00A5, 3'b000);
        checks++; if ({aw_valid, w_valid, w_last} !== 3'b111) begin errors++; $display("FAIL sb_valids: got %b expected 111", {aw_valid, w_valid, w_last}); end
        checks++; if (aw_size !== 3'd0) begin errors++; $display("FAIL sb_aw_size: got %0d expected 0", aw_size); end
        checks++; if ({aw_len, aw_burst} !== 10'b0000_0000_01) begin errors++; $display("FAIL sb_len_burst: got %b expected 0000000001", {aw_len, aw_burst}); end
        checks++; if (aw_addr !== 64'hA000_03F9) begin errors++; $display("FAIL sb_aw_addr: got %h expected 00000000a00003f9", aw_addr); end
        checks++; if (w_strb !== 8'h02) begin errors++; $display("FAIL sb_w_strb: got %h expected 02", w_strb); end
        checks++; if (w_data[15:8] !== 8'hA5) begin errors++; $display("FAIL sb_w_data: got %h expected a5", w_data[15:8]); end
        checks++; if (cache_valid !== 1'b0) begin errors++; $display("FAIL sb_no_cache: got %b expected 0", cache_valid); end
        aw_ready = 1'b1; w_ready = 1'b1;
        tick();
        aw_ready = 1'b0; w_ready = 1'b0;
        checks++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin errors++; $display("FAIL sb_to_b: got %b expected 001", {aw_valid, w_valid, b_ready}); end
        b_valid = 1'b1; b_resp = 2'b00;
        tick();
        b_valid = 1'b0;
        checks++; if ({resp_valid, resp_err, resp_skipref, b_ready} !== 4'b1010) begin errors++; $display("FAIL sb_resp: got %b expected 1010", {resp_valid, resp_err, resp_skipref, b_ready}); end
        finish_resp();
    endtask

    task automatic test_misaligned();
        issue(1'b1, 1'b0, 64'hA000_0001, 64'h0, 3'b001);
        checks++; if ({resp_valid, resp_err} !== 2'b11) begin errors++; $display("FAIL ma_resp: got %b expected 11", {resp_valid, resp_err}); end
        checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL ma_rdata: got %h expected 0", resp_rdata); end
        checks++; if ({ar_valid, aw_valid, cache_valid} !== 3'b000) begin errors++; $display("FAIL ma_no_bus: got %b expected 000", {ar_valid, aw_valid, cache_valid}); end
        finish_resp();
        checks++; if ({req_ready, ar_valid} !== 2'b10) begin errors++; $display("FAIL ma_idle: got %b expected 10", {req_ready, ar_valid}); end
    endtask

    task automatic test_store_w_first();
        issue(1'b0, 1'b1, 64'hA000_0010, 64'h0000_0000_1234_5678, 3'b010);
        checks++; if ({aw_size, w_strb} !== {3'd2, 8'h0F}) begin errors++; $display("FAIL wf_size_strb: got %h expected 20f", {aw_size, w_strb}); end
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({aw_valid, w_valid, b_ready} !== 3'b100) begin errors++; $display("FAIL wf_wait%0d: got %b expected 100", i, {aw_valid, w_valid, b_ready}); end
            if (i < 2) tick();
        end
        aw_ready = 1'b1;
        tick();
        aw_ready = 1'b0;
        checks++; if ({aw_valid, w_valid, b_ready} !== 3'b001) begin errors++; $display("FAIL wf_to_b: got %b expected 001", {aw_valid, w_valid, b_ready}); end
        b_valid = 1'b1; b_resp = 2'b00;
        tick();
        b_valid = 1'b0;
        checks++; if ({resp_valid, resp_err} !== 2'b10) begin errors++; $display("FAIL wf_resp: got %b expected 10", {resp_valid, resp_err}); end
        finish_resp();
    endtask

    task automatic test_device_load();
        issue(1'b1, 1'b0, 64'hA000_0006, 64'h0, 3'b001);
        checks++; if ({ar_valid, ar_size} !== {1'b1, 3'd1}) begin errors++; $display("FAIL dl_ar: got %b expected 1001", {ar_valid, ar_size}); end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        checks++; if ({ar_valid, r_ready} !== 2'b01) begin errors++; $display("FAIL dl_to_r: got %b expected 01", {ar_valid, r_ready}); end
        r_valid = 1'b1; r_data = 64'h8001_0000_0000_0000; r_resp = 2'b00;
        tick();
        r_valid = 1'b0;
        checks++; if (resp_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin errors++; $display("FAIL dl_rdata: got %h expected ffffffffffff8001", resp_rdata); end
        checks++; if ({resp_valid, resp_err, resp_skipref, r_ready} !== 4'b1010) begin errors++; $display("FAIL dl_resp: got %b expected 1010", {resp_valid, resp_err, resp_skipref, r_ready}); end
        finish_resp();
    endtask

    task automatic test_device_load_error();
        issue(1'b1, 1'b0, 64'hA000_0003, 64'h0, 3'b100);
        checks++; if ({ar_valid, ar_size, ar_addr[7:0]} !== {1'b1, 3'd0, 8'h03}) begin errors++; $display("FAIL le_ar: got %h expected 803", {ar_valid, ar_size, ar_addr[7:0]}); end
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        r_valid = 1'b1; r_data = 64'h0000_0000_FF00_0000; r_resp = 2'b10;
        tick();
        r_valid = 1'b0; r_resp = 2'b00;
        req_valid = 1'b1; req_ren = 1'b1; req_addr = 64'h8000_0000; req_func3 = 3'b011;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({resp_valid, resp_err, resp_skipref, req_ready} !== 4'b1110) begin errors++; $display("FAIL le_hold%0d: got %b expected 1110", i, {resp_valid, resp_err, resp_skipref, req_ready}); end
            checks++; if (resp_rdata !== 64'h0) begin errors++; $display("FAIL le_rdata%0d: got %h expected 0", i, resp_rdata); end
            tick();
        end
        req_valid = 1'b0; req_ren = 1'b0;
        finish_resp();
        checks++; if ({resp_valid, req_ready, cache_valid} !== 3'b010) begin errors++; $display("FAIL le_idle: got %b expected 010", {resp_valid, req_ready, cache_valid}); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, 64'hA000_0000, 64'h0, 3'b010);
        ar_ready = 1'b1;
        tick();
        ar_ready = 1'b0;
        checks++; if (r_ready !== 1'b1) begin errors++; $display("FAIL rm_in_r: got %b expected 1", r_ready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({r_ready, resp_valid, req_ready, ar_valid} !== 4'b0010) begin errors++; $display("FAIL rm_idle: got %b expected 0010", {r_ready, resp_valid, req_ready, ar_valid}); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_ren = 1'b0; req_wen = 1'b0;
        req_addr = '0; req_wdata = '0; req_func3 = '0;
        resp_ready = 1'b0;
        cache_rdata = '0; cache_dataok = 1'b0;
        ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00; r_last = 1'b1;
        aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = 2'b00;
        test_reset();
        test_cache_load();
        test_cache_store();
        test_device_store_byte();
        test_misaligned();
        test_store_w_first();
        test_device_load();
        test_device_load_error();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
